dram_dual_port: RTL and testbench
=================================

# dram_dual_port

Dual-port 16 x 16-bit memory that models a DRAM array with per-row charge retention and an explicit refresh input. Each port has an independent write strobe and read enable, and reads are registered. Any row not written, read or refreshed within `RETENTION_CYCLES` clocks loses its contents. The block serves as a behavioural DRAM model and storage element in the challenge design set, behind any controller that drives two independent access ports plus a periodic refresh strobe.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width.
- `ADDR_WIDTH`, 4, address width; depth = 2^ADDR_WIDTH rows, one word per row.
- `RETENTION_CYCLES`, 1024, clocks a row holds charge without restore; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we_a`  in  1  port A write strobe.
- `enable_a`  in  1  port A read enable.
- `addr_a`  in  ADDR_WIDTH  port A address.
- `data_in_a`  in  DATA_WIDTH  port A write data.
- `data_out_a`  out  DATA_WIDTH  port A registered read data.
- `we_b`, `enable_b`, `addr_b`, `data_in_b`, `data_out_b`: same as port A, for port B.
- `refresh_en`  in  1  refresh strobe; restores every row in the sampled cycle.

## Operation
- Storage: `mem[2^ADDR_WIDTH]` words. Each row has an age counter of width clog2(RETENTION_CYCLES+1).
- Write: `we_x`=1 at an edge writes `data_in_x` to `mem[addr_x]` and clears that row's age to 0.
- Read: `enable_x`=1 at an edge loads `data_out_x <= mem[addr_x]` (pre-edge contents) and clears that row's age to 0. With `enable_x`=0, `data_out_x` holds its value.
- Port with `we_x` and `enable_x` both set: the write occurs and the read returns the old data (read-first).
- Refresh: `refresh_en`=1 at an edge clears all ages to 0. Data is unchanged and port accesses in the same cycle proceed normally; refresh never stalls or blocks a port.
- Aging: every other row's age increments by 1 each edge, saturating at RETENTION_CYCLES. When a row's age reaches RETENTION_CYCLES, that row's data becomes 0 on the same edge (decayed). A later write restores it.
- Collisions:
  - Both ports write the same address: port A data is stored.
  - One port reads an address the other writes in the same cycle: the read returns old data.
  - Write, read or refresh takes priority over decay on the same edge.

## Timing
- Read latency: 1 clock. Data appears after the edge that samples `enable_x`.
- Write visible to either port's read on the next cycle.
- Inputs are sampled only at rising edges; there is no handshake.
- Reset (`rst_n`=0, asynchronous, at any time including mid-access): `data_out_a`=`data_out_b`=0, all `mem` words = 0, all ages = 0. Accesses in progress are discarded. Normal operation resumes at the first edge with `rst_n`=1.
- Address range: addresses cover the full depth, so there is no out-of-range case; rows 0 and 15 behave like any other row.

## Test plan
- Dual write/read: A writes 0xA5A5@4 and B writes 0x5A5A@8 in one cycle. Next cycle, read A@4 and B@8 → `data_out_a`=0xA5A5 and `data_out_b`=0x5A5A one edge later.
- Refresh transparency: write 0xFACE@2 and 0xDEAD@6, pulse `refresh_en` for 1 cycle, write 0x1111@1 and 0xFFFF@15 in the following cycle. All four words read back intact; the post-refresh writes are not lost.
- Overwrite and hold: write 0x1A2B@0, then 0x1234@0 and 0x5678@15, then read. Result is 0x1234/0x5678. Then deassert enables for 3 cycles → outputs hold 0x1234/0x5678.
- Collision: A writes 0xAAAA@9 and B writes 0x5555@9 in the same cycle → read@9 returns 0xAAAA. B reads @9 while A writes 0xBEEF@9 → B gets 0xAAAA, and the next read gets 0xBEEF.
- Retention (`RETENTION_CYCLES`=8): write 0xDEAD@3 and idle 8 cycles → read@3 returns 0. Repeat with `refresh_en` pulsed every 5 cycles → read@3 returns 0xDEAD.
- Async reset mid-operation: after writing 0xBEEF@5 and reading it, assert `rst_n`=0 between edges. Outputs go to 0 immediately; after release, read@5 returns 0.

Source files
------------

// File: rtl/dram_dual_port.sv
// dram_dual_port
//   Dual-port behavioural DRAM array: 2^ADDR_WIDTH rows of DATA_WIDTH bits.
//   Each row keeps an age counter. The counter restarts on any write, read or
//   refresh of that row. When a row goes RETENTION_CYCLES clocks without being
//   restored, its contents decay to zero.
//
// Ports
//   clk                   single clock, rising-edge active
//   rst_n                 asynchronous active-low reset (clears data, ages, outputs)
//   we_a / we_b           write strobes
//   enable_a / enable_b   read enables (registered read, read-first)
//   addr_a / addr_b       row addresses
//   data_in_a / data_in_b write data
//   data_out_a / data_out_b  registered read data; holds its value while the read enable is low
//   refresh_en            restores every row on the sampled edge
module dram_dual_port #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 4,
    parameter int RETENTION_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic                  enable_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic                  we_b,
    input  logic                  enable_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  refresh_en
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AGE_W = $clog2(RETENTION_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RETENTION_CYCLES);

    // Read view of all rows. Each row lives in its own generate scope because
    // the whole array has to clear on reset, so it cannot map onto block RAM.
    logic [DATA_WIDTH-1:0] mem_view [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            logic                  wr_a_hit;
            logic                  wr_b_hit;
            logic                  rd_hit;
            logic                  restore;
            logic [AGE_W-1:0]      age_reg;
            logic [AGE_W-1:0]      age_next;
            logic [DATA_WIDTH-1:0] row_data_reg;

            assign wr_a_hit = we_a && (addr_a == ADDR_WIDTH'(gi));
            assign wr_b_hit = we_b && (addr_b == ADDR_WIDTH'(gi));
            assign rd_hit   = (enable_a && (addr_a == ADDR_WIDTH'(gi))) ||
                              (enable_b && (addr_b == ADDR_WIDTH'(gi)));
            assign restore  = wr_a_hit || wr_b_hit || rd_hit || refresh_en;

            always_comb begin
                age_next = age_reg;
                if (restore) begin
                    age_next = '0;
                end else if (age_reg != AGE_MAX) begin
                    age_next = age_reg + AGE_W'(1);
                end
            end

            // Port A wins a same-row write collision. Decay applies only when
            // nothing restored the row on this edge, because a restored row has
            // age_next == 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_reg      <= '0;
                    row_data_reg <= '0;
                end else begin
                    age_reg <= age_next;
                    if (wr_a_hit) begin
                        row_data_reg <= data_in_a;
                    end else if (wr_b_hit) begin
                        row_data_reg <= data_in_b;
                    end else if (age_next == AGE_MAX) begin
                        row_data_reg <= '0;
                    end
                end
            end

            assign mem_view[gi] = row_data_reg;
        end
    endgenerate

    // Registered reads sample the pre-edge contents. This gives read-first
    // behaviour against both ports' writes on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            if (enable_a) begin
                data_out_a <= mem_view[addr_a];
            end
            if (enable_b) begin
                data_out_b <= mem_view[addr_b];
            end
        end
    end

endmodule

// File: tb/tb_dram_dual_port.sv
module tb_dram_dual_port;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int RET = 8;
    localparam int DEP = 16;

    logic          clk;
    logic          rst_n;
    logic          we_a, enable_a, we_b, enable_b, refresh_en;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_in_a, data_in_b, data_out_a, data_out_b;

    dram_dual_port #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .RETENTION_CYCLES(RET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_a      (we_a),
        .enable_a  (enable_a),
        .addr_a    (addr_a),
        .data_in_a (data_in_a),
        .data_out_a(data_out_a),
        .we_b      (we_b),
        .enable_b  (enable_b),
        .addr_b    (addr_b),
        .data_in_b (data_in_b),
        .data_out_b(data_out_b),
        .refresh_en(refresh_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stored word and the number of idle clocks since
    // the last restore, for every row.
    int      m_data [DEP];
    int      m_idle [DEP];
    int      m_out_a, m_out_b;
    int      checks = 0;
    int      fails  = 0;

    task automatic model_reset();
        for (int r = 0; r < DEP; r++) begin
            m_data[r] = 0;
            m_idle[r] = 0;
        end
        m_out_a = 0;
        m_out_b = 0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, advance the model, and check both outputs
    // at the following falling edge.
    task automatic cyc(input logic wa, input logic ea, input int aa, input int da,
                       input logic wb, input logic eb, input int ab, input int db,
                       input logic rf);
        int old_data [DEP];
        we_a = wa; enable_a = ea; addr_a = AW'(aa); data_in_a = DW'(da);
        we_b = wb; enable_b = eb; addr_b = AW'(ab); data_in_b = DW'(db);
        refresh_en = rf;
        @(posedge clk);
        old_data = m_data;
        if (ea) m_out_a = old_data[aa];
        if (eb) m_out_b = old_data[ab];
        for (int r = 0; r < DEP; r++) begin
            if (rf || (wa && aa == r) || (wb && ab == r) || (ea && aa == r) || (eb && ab == r))
                m_idle[r] = 0;
            else if (m_idle[r] < RET)
                m_idle[r] = m_idle[r] + 1;
            if (wa && aa == r)       m_data[r] = da;
            else if (wb && ab == r)  m_data[r] = db;
            else if (m_idle[r] >= RET) m_data[r] = 0;
        end
        @(negedge clk);
        $display("cyc wa=%0b ea=%0b aa=%0d da=%h wb=%0b eb=%0b ab=%0d db=%h rf=%0b -> out_a=%h out_b=%h",
                 wa, ea, aa, DW'(da), wb, eb, ab, DW'(db), rf, data_out_a, data_out_b);
        chk("model_out_a", data_out_a, DW'(m_out_a));
        chk("model_out_b", data_out_b, DW'(m_out_b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        we_a = 0; enable_a = 0; addr_a = '0; data_in_a = '0;
        we_b = 0; enable_b = 0; addr_b = '0; data_in_b = '0;
        refresh_en = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out_a", data_out_a, 16'h0000);
        chk("reset_out_b", data_out_b, 16'h0000);
        rst_n = 1'b1;

        // Dual write / read
        cyc(1, 0, 4, 'hA5A5, 1, 0, 8, 'h5A5A, 0);
        cyc(0, 1, 4, 0, 0, 1, 8, 0, 0);
        chk("dual_rd_a", data_out_a, 16'hA5A5);
        chk("dual_rd_b", data_out_b, 16'h5A5A);

        // Refresh transparency
        cyc(1, 0, 2, 'hFACE, 1, 0, 6, 'hDEAD, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 'h1111, 1, 0, 15, 'hFFFF, 0);
        cyc(0, 1, 2, 0, 0, 1, 6, 0, 0);
        chk("refr_rd_2", data_out_a, 16'hFACE);
        chk("refr_rd_6", data_out_b, 16'hDEAD);
        cyc(0, 1, 1, 0, 0, 1, 15, 0, 0);
        chk("refr_rd_1", data_out_a, 16'h1111);
        chk("refr_rd_15", data_out_b, 16'hFFFF);

        // Overwrite and hold
        cyc(1, 0, 0, 'h1A2B, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 'h1234, 1, 0, 15, 'h5678, 0);
        cyc(0, 1, 0, 0, 0, 1, 15, 0, 0);
        chk("ovw_rd_0", data_out_a, 16'h1234);
        chk("ovw_rd_15", data_out_b, 16'h5678);
        idle(3);
        chk("hold_a", data_out_a, 16'h1234);
        chk("hold_b", data_out_b, 16'h5678);

        // Collision
        cyc(1, 0, 9, 'hAAAA, 1, 0, 9, 'h5555, 0);
        cyc(0, 1, 9, 0, 0, 0, 0, 0, 0);
        chk("coll_ww", data_out_a, 16'hAAAA);
        cyc(1, 0, 9, 'hBEEF, 0, 1, 9, 0, 0);
        chk("coll_rw_old", data_out_b, 16'hAAAA);
        cyc(0, 0, 0, 0, 0, 1, 9, 0, 0);
        chk("coll_rw_new", data_out_b, 16'hBEEF);

        // Retention: eight idle clocks decay the row
        cyc(1, 0, 3, 'hDEAD, 0, 0, 0, 0, 0);
        idle(RET);
        cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("decay_3", data_out_a, 16'h0000);
        // The same gap with a refresh every fifth clock keeps the data
        cyc(1, 0, 3, 'hDEAD, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, (i % 5) == 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("refr_keep_3", data_out_a, 16'hDEAD);
        // Seven idle clocks after a write still leave the row intact
        cyc(0, 0, 0, 0, 1, 0, 12, 'h7E57, 0);
        idle(RET - 1);
        cyc(0, 0, 0, 0, 0, 1, 12, 0, 0);
        chk("edge_keep_12", data_out_b, 16'h7E57);

        // Randomized traffic, addresses biased to a small window for collisions
        for (int i = 0; i < 400; i++) begin
            int narrow;
            narrow = ($urandom_range(0, 1) == 1) ? 4 : 16;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, narrow - 1), $urandom_range(0, 16'hFFFF),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, narrow - 1), $urandom_range(0, 16'hFFFF),
                $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset between edges
        cyc(1, 0, 5, 'hBEEF, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 0, 1, 5, 0, 0);
        chk("pre_rst_a", data_out_a, 16'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", data_out_a, 16'h0000);
        chk("async_rst_b", data_out_b, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 5, 0, 0, 1, 5, 0, 0);
        chk("post_rst_rd5", data_out_a, 16'h0000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
